// File: rtl/sdram_refresh_ctrl_pkg.sv
// Shared SDRAM definitions: command encodings, refresh FSM states and a width helper.
package sdram_refresh_ctrl_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CmdNop       = 4'b0111;
  localparam logic [3:0] CmdPrecharge = 4'b0010;
  localparam logic [3:0] CmdAutoRef   = 4'b0001;
  // Self-refresh entry is AUTO_REF issued with CKE low
  localparam logic [3:0] CmdSelfRef   = 4'b0001;

  typedef enum logic [3:0] {
    StIdle,
    StReq,
    StSrReq,
    StPre,
    StWaitTrp,
    StRef,
    StWaitTrfc,
    StSrEntry,
    StSrHold,
    StSrXsr,
    StPostRef,
    StWaitPost
  } ref_state_e;

  // Bits needed to hold values 0..max_val (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sdram_refresh_ctrl_timer.sv
// Refresh interval timer, postponed-refresh counter and sticky overrun flag.
module sdram_refresh_ctrl_timer
  import sdram_refresh_ctrl_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = 1560,
  parameter int unsigned MAX_PENDING  = 8,
  localparam int unsigned TimerW      = cnt_width(REF_INTERVAL - 1),
  localparam int unsigned PendW       = cnt_width(MAX_PENDING)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_init,
  input  logic             i_restart,
  input  logic             i_ref_done,
  output logic             o_tick,
  output logic [PendW-1:0] o_pending,
  output logic             o_overrun
);

  logic [TimerW-1:0] r_timer, w_timer_d;
  logic [PendW-1:0]  r_pending, w_pending_d;
  logic              r_overrun, w_overrun_d;
  logic              w_tick;
  logic              w_sat;

  // Next-state for timer, pending count and overrun flag
  always_comb begin
    w_sat       = (r_pending == PendW'(MAX_PENDING));
    w_tick      = i_init && !i_restart && (r_timer == TimerW'(REF_INTERVAL - 1));
    w_timer_d   = r_timer + TimerW'(1);
    w_pending_d = r_pending;
    w_overrun_d = r_overrun | (w_tick && w_sat);
    if (!i_init || i_restart) begin
      // Held at zero while uninitialised or while the device refreshes itself
      w_timer_d   = '0;
      w_pending_d = '0;
    end else begin
      if (w_tick) begin
        w_timer_d = '0;
      end
      if (w_tick && !i_ref_done && !w_sat) begin
        w_pending_d = r_pending + PendW'(1);
      end else if (!w_tick && i_ref_done && (r_pending != '0)) begin
        w_pending_d = r_pending - PendW'(1);
      end
    end
  end

  // Timer state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer   <= '0;
      r_pending <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_timer   <= w_timer_d;
      r_pending <= w_pending_d;
      r_overrun <= w_overrun_d;
    end
  end

  assign o_tick    = w_tick;
  assign o_pending = r_pending;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/sdram_refresh_ctrl.sv
// SDRAM refresh engine: periodic auto-refresh with postponement, self-refresh entry/exit.
module sdram_refresh_ctrl
  import sdram_refresh_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned BA_W           = 2,
  parameter int unsigned TRP            = 2,
  parameter int unsigned TRFC           = 7,
  parameter int unsigned TXSR           = 8,
  parameter int unsigned TCKESR         = 4,
  parameter int unsigned REF_INTERVAL   = 1560,
  parameter int unsigned MAX_PENDING    = 8,
  parameter int unsigned EXIT_REFRESHES = 1
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst_n,
  input  logic              i_sdram_init,
  input  logic              i_self_ref_en,
  input  logic              i_bus_gnt,
  output logic              o_bus_req,
  output logic              o_sdram_cke,
  output logic [3:0]        o_sdram_cmd,
  output logic [BA_W-1:0]   o_sdram_ba,
  output logic [ADDR_W-1:0] o_sdram_addr,
  output logic              o_sr_active,
  output logic              o_self_ref_done,
  output logic              o_ref_overrun
);

  localparam int unsigned TMaxA = (TRP > TRFC) ? TRP : TRFC;
  localparam int unsigned TMaxB = (TXSR > TCKESR) ? TXSR : TCKESR;
  localparam int unsigned TMax  = (TMaxA > TMaxB) ? TMaxA : TMaxB;
  localparam int unsigned CntW  = cnt_width(TMax);
  localparam int unsigned PendW = cnt_width(MAX_PENDING);
  localparam int unsigned PostW = cnt_width(EXIT_REFRESHES);

  ref_state_e       r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [PostW-1:0] r_post, w_post_d, w_post_inc;
  logic             r_sr_seq, w_sr_seq_d;
  logic             r_done, w_done_d;

  logic             w_tick;
  logic [PendW-1:0] w_pending;
  logic             w_ref_done;
  logic             w_restart;
  logic             w_cnt_last;
  logic             w_ref_more;
  ref_state_e       w_after_trp;
  ref_state_e       w_ref_next;

  sdram_refresh_ctrl_timer #(
    .REF_INTERVAL (REF_INTERVAL),
    .MAX_PENDING  (MAX_PENDING)
  ) u_timer (
    .i_clk      (i_sys_clk),
    .i_rst_n    (i_sys_rst_n),
    .i_init     (i_sdram_init),
    .i_restart  (w_restart),
    .i_ref_done (w_ref_done),
    .o_tick     (w_tick),
    .o_pending  (w_pending),
    .o_overrun  (o_ref_overrun)
  );

  // Precharge-all via A10; the bus is parked at all ones otherwise
  assign o_sdram_ba   = '1;
  assign o_sdram_addr = '1;

  assign w_cnt_last  = (r_cnt <= CntW'(1));
  assign w_post_inc  = r_post + PostW'(1);
  assign w_after_trp = r_sr_seq ? StSrEntry : StRef;
  // Refreshes still owed after this one completes (a same-cycle tick replaces it)
  assign w_ref_more  = (w_pending > PendW'(1)) || w_tick;
  assign w_ref_next  = (w_ref_more && !i_self_ref_en) ? StRef : StIdle;

  // Next-state and command/pin decode
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = (r_cnt != '0) ? r_cnt - CntW'(1) : '0;
    w_post_d    = r_post;
    w_sr_seq_d  = r_sr_seq;
    w_done_d    = 1'b0;
    w_ref_done  = 1'b0;
    w_restart   = 1'b0;
    o_bus_req   = 1'b1;
    o_sdram_cke = 1'b1;
    o_sdram_cmd = CmdNop;
    o_sr_active = 1'b0;
    case (r_state)
      StIdle: begin
        o_bus_req = 1'b0;
        if (i_sdram_init) begin
          if (i_self_ref_en) begin
            w_state_d  = StSrReq;
            w_sr_seq_d = 1'b1;
          end else if ((w_pending != '0) || w_tick) begin
            w_state_d  = StReq;
            w_sr_seq_d = 1'b0;
          end
        end
      end
      StReq, StSrReq: begin
        if (i_bus_gnt) begin
          w_state_d = StPre;
        end
      end
      StPre: begin
        o_sdram_cmd = CmdPrecharge;
        w_cnt_d     = CntW'(TRP - 1);
        w_state_d   = (TRP > 1) ? StWaitTrp : w_after_trp;
      end
      StWaitTrp: begin
        if (w_cnt_last) begin
          w_state_d = w_after_trp;
        end
      end
      StRef: begin
        o_sdram_cmd = CmdAutoRef;
        w_cnt_d     = CntW'(TRFC - 1);
        if (TRFC > 1) begin
          w_state_d = StWaitTrfc;
        end else begin
          w_ref_done = 1'b1;
          w_state_d  = w_ref_next;
        end
      end
      StWaitTrfc: begin
        if (w_cnt_last) begin
          w_ref_done = 1'b1;
          w_state_d  = w_ref_next;
        end
      end
      StSrEntry: begin
        o_sdram_cmd = CmdSelfRef;
        o_sdram_cke = 1'b0;
        o_sr_active = 1'b1;
        w_restart   = 1'b1;
        w_cnt_d     = CntW'(TCKESR - 1);
        w_state_d   = StSrHold;
      end
      StSrHold: begin
        o_sdram_cke = 1'b0;
        o_sr_active = 1'b1;
        // Device refreshes itself; keep the interval from accumulating debt
        w_restart   = 1'b1;
        if (!i_self_ref_en && w_cnt_last) begin
          w_state_d = StSrXsr;
          w_cnt_d   = CntW'(TXSR);
        end
      end
      StSrXsr: begin
        if (w_cnt_last) begin
          w_state_d = StPostRef;
          w_post_d  = '0;
        end
      end
      StPostRef: begin
        o_sdram_cmd = CmdAutoRef;
        w_cnt_d     = CntW'(TRFC - 1);
        w_post_d    = w_post_inc;
        if (TRFC > 1) begin
          w_state_d = StWaitPost;
        end else if (w_post_inc >= PostW'(EXIT_REFRESHES)) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
        end
      end
      StWaitPost: begin
        if (w_cnt_last) begin
          if (r_post >= PostW'(EXIT_REFRESHES)) begin
            w_state_d = StIdle;
            w_done_d  = 1'b1;
          end else begin
            w_state_d = StPostRef;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // FSM state and shared timing counter
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_post   <= '0;
      r_sr_seq <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_post   <= w_post_d;
      r_sr_seq <= w_sr_seq_d;
      r_done   <= w_done_d;
    end
  end

  assign o_self_ref_done = r_done;

endmodule

// File: tb/tb_sdram_refresh_ctrl.sv
// Directed self-checking bench for sdram_refresh_ctrl (REF_INTERVAL shortened to 100).
module tb_sdram_refresh_ctrl;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init = 1'b0;
  logic        sr_en = 1'b0;
  logic        gnt = 1'b0;
  logic        bus_req, cke, sr_active, done, overrun;
  logic [3:0]  cmd;
  logic [1:0]  ba;
  logic [11:0] addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sdram_refresh_ctrl #(
    .REF_INTERVAL (100)
  ) dut (
    .i_sys_clk       (clk),
    .i_sys_rst_n     (rst_n),
    .i_sdram_init    (init),
    .i_self_ref_en   (sr_en),
    .i_bus_gnt       (gnt),
    .o_bus_req       (bus_req),
    .o_sdram_cke     (cke),
    .o_sdram_cmd     (cmd),
    .o_sdram_ba      (ba),
    .o_sdram_addr    (addr),
    .o_sr_active     (sr_active),
    .o_self_ref_done (done),
    .o_ref_overrun   (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cyc, nref, npre, first, prev, gap_ok, ok, b17;

    // Reset values
    step(2);
    chk("rst_cke", cke, 1);
    chk("rst_cmd", cmd, NOP);
    chk("rst_ba", ba, 2'b11);
    chk("rst_addr", addr, 12'hFFF);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_sr_active", sr_active, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);

    // 1: first periodic refresh
    rst_n = 1'b1; init = 1'b1; gnt = 1'b1;
    cyc = 0;
    while (!bus_req && cyc < 200) begin
      step(1);
      cyc++;
    end
    chk("t1_first_req_cycle", cyc, 100);
    step(1);
    chk("t1_precharge", cmd, PRE);
    chk("t1_a10", addr[10], 1);
    step(1);
    chk("t1_trp_nop", cmd, NOP);
    step(1);
    chk("t1_auto_ref", cmd, REF);
    chk("t1_auto_ref_cke", cke, 1);
    ok = 1;
    repeat (6) begin
      step(1);
      if (cmd !== NOP || bus_req !== 1'b1) ok = 0;
    end
    chk("t1_trfc_nops", ok, 1);
    step(1);
    chk("t1_bus_release", bus_req, 0);
    chk("t1_release_nop", cmd, NOP);

    // 2: five postponed refreshes drained behind one precharge (now at cycle 110)
    gnt = 1'b0;
    step(540);
    chk("t2_req_held", bus_req, 1);
    gnt = 1'b1;
    step(1);
    chk("t2_precharge", cmd, PRE);
    nref = 0; npre = 0; first = 0; prev = 0; gap_ok = 1;
    for (int i = 1; i <= 44; i++) begin
      step(1);
      if (cmd === REF) begin
        if (nref == 0) first = i;
        else if (i - prev != 7) gap_ok = 0;
        prev = i;
        nref++;
      end
      if (cmd === PRE) npre++;
    end
    chk("t2_ref_count", nref, 5);
    chk("t2_first_ref", first, 2);
    chk("t2_ref_spacing", gap_ok, 1);
    chk("t2_no_reprecharge", npre, 0);
    chk("t2_idle", bus_req, 0);

    // 2b: overrun on the ninth postponed tick (now at cycle 695)
    gnt = 1'b0;
    step(755);
    chk("t2_no_overrun_at_8", overrun, 0);
    step(60);
    chk("t2_overrun_at_9", overrun, 1);
    gnt = 1'b1;
    cyc = 0; nref = 0;
    step(1);
    while (bus_req && cyc < 200) begin
      if (cmd === REF) nref++;
      step(1);
      cyc++;
    end
    chk("t2_drain_bounded", (cyc < 200), 1);
    chk("t2_drain_refs", nref, 8);

    // 3: self-refresh entry and exit
    sr_en = 1'b1;
    step(1);
    chk("t3_sr_req", bus_req, 1);
    step(1);
    chk("t3_precharge", cmd, PRE);
    step(1);
    chk("t3_trp_nop", cmd, NOP);
    step(1);
    chk("t3_self_ref_cmd", cmd, REF);
    chk("t3_self_ref_cke", cke, 0);
    chk("t3_sr_active", sr_active, 1);
    step(50);
    chk("t3_hold_cke", cke, 0);
    chk("t3_hold_cmd", cmd, NOP);
    chk("t3_hold_bus_req", bus_req, 1);
    sr_en = 1'b0;
    step(1);
    chk("t3_exit_cke", cke, 1);
    chk("t3_exit_sr_active", sr_active, 0);
    ok = (cmd === NOP);
    repeat (7) begin
      step(1);
      if (cmd !== NOP || cke !== 1'b1) ok = 0;
    end
    chk("t3_xsr_nops", ok, 1);
    step(1);
    chk("t3_post_ref", cmd, REF);
    step(6);
    chk("t3_done_early", done, 0);
    chk("t3_busy_in_trfc", bus_req, 1);
    step(1);
    chk("t3_done_pulse", done, 1);
    chk("t3_release", bus_req, 0);
    step(1);
    chk("t3_done_one_cycle", done, 0);

    // 4: one-cycle self-refresh request keeps CKE low exactly TCKESR cycles
    sr_en = 1'b1;
    step(1);
    sr_en = 1'b0;
    cyc = 0;
    while (cke && cyc < 20) begin
      step(1);
      cyc++;
    end
    chk("t4_entry_delay", cyc, 3);
    cyc = 0;
    while (!cke && cyc < 50) begin
      cyc++;
      step(1);
    end
    chk("t4_cke_low_cycles", cyc, 4);
    cyc = 0;
    while (!done && cyc < 50) begin
      step(1);
      cyc++;
    end
    chk("t4_done_latency", cyc, 15);

    // 5a: tick lands on the last TRFC cycle -> one extra refresh, no re-precharge
    init = 1'b0; gnt = 1'b0;
    step(5);
    chk("t5_init_low_idle", bus_req, 0);
    init = 1'b1;
    step(100);
    chk("t5_tick_req", bus_req, 1);
    step(90);
    gnt = 1'b1;
    nref = 0; npre = 0; prev = 0; b17 = 1;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (cmd === REF) begin
        nref++;
        prev = i;
      end
      if (cmd === PRE) npre++;
      if (i == 17) b17 = bus_req;
    end
    chk("t5_ref_count", nref, 2);
    chk("t5_precharge_count", npre, 1);
    chk("t5_second_ref_pos", prev, 10);
    chk("t5_idle_after", b17, 0);

    // 5b: self-refresh requested with three refreshes owed
    gnt = 1'b0;
    step(280);
    chk("t5b_req_waiting", bus_req, 1);
    sr_en = 1'b1; gnt = 1'b1;
    cyc = 0; nref = 0;
    while (cke && cyc < 40) begin
      step(1);
      cyc++;
      if (cke && cmd === REF) nref++;
    end
    chk("t5b_entry_cycle", cyc, 14);
    chk("t5b_refs_before_sr", nref, 1);
    chk("t5b_sr_cmd", cmd, REF);
    step(5);
    sr_en = 1'b0;
    cyc = 0;
    while (!done && cyc < 60) begin
      step(1);
      cyc++;
    end
    chk("t5b_done_seen", done, 1);
    ok = 1;
    repeat (60) begin
      step(1);
      if (bus_req) ok = 0;
    end
    chk("t5b_pending_cleared", ok, 1);

    // 6: asynchronous reset during self-refresh hold
    chk("t6_overrun_sticky", overrun, 1);
    sr_en = 1'b1;
    cyc = 0;
    while (!sr_active && cyc < 20) begin
      step(1);
      cyc++;
    end
    step(3);
    chk("t6_in_hold", sr_active, 1);
    chk("t6_hold_cke", cke, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_cke", cke, 1);
    chk("t6_async_cmd", cmd, NOP);
    chk("t6_async_bus_req", bus_req, 0);
    chk("t6_async_sr_active", sr_active, 0);
    chk("t6_async_overrun", overrun, 0);
    sr_en = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
